uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter for the UART block pair. Accepts parallel bytes over a ready/start handshake and drives them on a single line as 8N1-style frames: start bit (0), 8 data bits LSB first, 1 or 2 stop bits (1). The default bit period is one `clk` cycle, matching the one-bit-per-clock receiver. A one-entry holding register lets frames go out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 1: bit period in `clk` cycles; legal range ≥1.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to send `data_in`; accepted on a rising edge when `ready`=1.
- `data_in`  in  8  byte to send; sampled only on acceptance.
- `ready`  out  1  high when a byte can be accepted (holding register empty).
- `out`  out  1  serial line, registered; idles high.
- `busy`  out  1  high while a frame is being shifted (START/DATA/STOP).
- `done`  out  1  one-cycle pulse after the final stop bit of each frame completes.

## Operation
- One clock; `rst` is asynchronous and active-high.
- State machine states: IDLE, START, DATA, STOP. Also:
  - 8-bit shift register.
  - 8-bit holding register with a `hold_full` flag.
  - bit-timer counting 0..CLKS_PER_BIT-1, width max(1, clog2(CLKS_PER_BIT)).
  - 3-bit data-bit index.
  - stop counter.
- Accept = `start` & `ready`. `ready` = !`hold_full`.
- IDLE + accept: load `data_in` into the shift register and go to START. The holding register stays empty and `ready` stays 1.
- START/DATA/STOP + accept: load `data_in` into the holding register and set `hold_full`. `ready` goes 0 the next cycle.
- `start` while `ready`=0 is ignored. `data_in` is not sampled and no state changes.
- START: drive `out`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA: drive `out`=shift[index] for CLKS_PER_BIT cycles per bit, LSB first. After index 7 expires, go to STOP.
- STOP: drive `out`=1 for STOP_BITS×CLKS_PER_BIT cycles. On expiry:
  - pulse `done`.
  - if `hold_full`: move the holding register into the shift register, clear `hold_full`, go directly to START (no idle bit).
  - otherwise: go to IDLE.
- Accept in the same cycle the holding register drains (final stop cycle): the new byte is written into the holding register. Drain and fill are both legal; `hold_full` ends at 1.
- IDLE: `out`=1, `busy`=0.
- `data_in` changes after acceptance have no effect on the frame in flight or the buffered byte.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `out`=1, `busy`=0, `done`=0, `ready`=1.
  - `hold_full`=0, counters=0, shift and holding registers=0.
- Reset mid-frame: `out` returns to 1 immediately. The frame and the buffered byte are discarded. The first accept after release starts a clean frame.
- Latency: accept at edge t → `out`=0 and `busy`=1 from cycle t+1.
  - Data bit i occupies cycles t+1+(i+1)·CPB … t+(i+2)·CPB.
  - Stop bits follow. Frame length = (9+STOP_BITS)·CPB cycles.
- `done` is high in the single cycle following the last stop-bit cycle. With back-to-back frames, it coincides with the next start bit.
- `busy` stays 1 across back-to-back frames. It falls in the same cycle `done` pulses if no byte is buffered.
- `ready` falls the cycle after a buffering accept. It rises the cycle after the holding register drains.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `out`=1, `ready`=1, `busy`=0, `done`=0 immediately; release, idle 5 cycles → outputs unchanged.
- Single frame, CPB=1, STOP_BITS=1: accept 0xA5 at edge 0.
  - `out` over cycles 1..10 = 0,1,0,1,0,0,1,0,1,1.
  - `busy`=1 for cycles 1..10; `done`=1 only in cycle 11; `ready` stays 1.
- Back-to-back: accept 0x00, then 0xFF at cycle 3.
  - `ready`=0 from cycle 4 to cycle 11.
  - `out` = 0,0×8,1 then 0,1×8,1 contiguous over cycles 1..20, no idle bit.
  - `done` in cycles 11 and 21.
- Ignored request: while `ready`=0, pulse `start` with 0x3C → not transmitted; only the two buffered frames appear.
- CPB=4, STOP_BITS=2: accept 0x81.
  - Each bit is held 4 cycles; frame is 44 cycles: start 4×0, bit0 4×1, bits1..6 24×0, bit7 4×1, stop 8×1.
  - `done` in cycle 45.
- Reset mid-DATA: assert `rst` during bit 3 of 0xF0 with a byte buffered.
  - `out`=1 and `busy`=0 immediately; buffered byte lost.
  - After release, accept 0x55 → a correct single frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial outputs of the UART transmitter.
interface uart_tx_if;
  logic       start;
  logic [7:0] data_in;
  logic       ready;
  logic       out;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, 1 or 2 stop bits,
// with a one-entry holding register so frames can run back to back.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_full;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic          stop_cnt;
  logic          out_q;
  logic          busy_q;
  logic          done_q;
  logic          ready_q;

  logic accept_c;
  logic bit_end_c;

  assign accept_c  = bus.start & ready_q;
  assign bit_end_c = (timer == T_LAST);

  assign bus.out   = out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= 8'h00;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      timer     <= '0;
      idx       <= 3'd0;
      stop_cnt  <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q  <= 1'b0;
      // ready trails the holding flag by one cycle when it drains
      ready_q <= ~hold_full;

      case (state)
        IDLE: begin
          out_q  <= 1'b1;
          busy_q <= 1'b0;
          if (accept_c) begin
            shift  <= bus.data_in;
            state  <= START;
            timer  <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (bit_end_c) begin
            timer <= '0;
            idx   <= 3'd0;
            state <= DATA;
            out_q <= shift[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DATA: begin
          if (bit_end_c) begin
            timer <= '0;
            if (idx == 3'd7) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              out_q    <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              out_q <= shift[3'(idx + 3'd1)];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        STOP: begin
          if (bit_end_c) begin
            timer <= '0;
            if (stop_cnt == S_LAST) begin
              done_q   <= 1'b1;
              stop_cnt <= 1'b0;
              if (hold_full) begin
                // chain straight into the buffered frame, no idle bit
                shift     <= hold;
                hold_full <= 1'b0;
                state     <= START;
                out_q     <= 1'b0;
              end else begin
                state  <= IDLE;
                out_q  <= 1'b1;
                busy_q <= 1'b0;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          out_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase

      // buffering accept overrides the drain above so the new byte is kept
      if (accept_c && state != IDLE) begin
        hold      <= bus.data_in;
        hold_full <= 1'b1;
        ready_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back frames,
// ignored request, slow/2-stop configuration and reset mid-frame.
module tb_uart_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_tx_if b1 ();
  uart_tx_if b2 ();

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  f_a5;
  logic [19:0] f_b2b;
  logic [10:0] f_81;
  logic [9:0]  f_55;

  initial begin
    total = 0;
    bad   = 0;
    f_a5  = 10'h34A;
    f_b2b = 20'hFFA00;
    f_81  = 11'h702;
    f_55  = 10'h2AA;
    rst   = 1'b0;
    b1.start = 1'b0; b1.data_in = 8'h00;
    b2.start = 1'b0; b2.data_in = 8'h00;

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_out",   0, 8'(b1.out),   8'h1);
    chk("rst_ready", 0, 8'(b1.ready), 8'h1);
    chk("rst_busy",  0, 8'(b1.busy),  8'h0);
    chk("rst_done",  0, 8'(b1.done),  8'h0);
    chk("rst_out2",  0, 8'(b2.out),   8'h1);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_out",   c, 8'(b1.out),   8'h1);
      chk("idle_busy",  c, 8'(b1.busy),  8'h0);
      chk("idle_done",  c, 8'(b1.done),  8'h0);
      chk("idle_ready", c, 8'(b1.ready), 8'h1);
    end

    // single frame 0xA5
    b1.start = 1'b1; b1.data_in = 8'hA5;
    step();
    b1.start = 1'b0; b1.data_in = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      chk("a5_out",   c, 8'(b1.out),   8'(f_a5[c-1]));
      chk("a5_busy",  c, 8'(b1.busy),  8'h1);
      chk("a5_done",  c, 8'(b1.done),  8'h0);
      chk("a5_ready", c, 8'(b1.ready), 8'h1);
      step();
    end
    chk("a5_done11", 11, 8'(b1.done), 8'h1);
    chk("a5_busy11", 11, 8'(b1.busy), 8'h0);
    chk("a5_out11",  11, 8'(b1.out),  8'h1);
    step();
    chk("a5_done12", 12, 8'(b1.done), 8'h0);
    step();

    // back-to-back 0x00 then 0xFF, plus an ignored request of 0x3C
    b1.start = 1'b1; b1.data_in = 8'h00;
    step();
    b1.start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c <= 20) begin
        chk("b2b_out",  c, 8'(b1.out),  8'(f_b2b[c-1]));
        chk("b2b_busy", c, 8'(b1.busy), 8'h1);
      end else begin
        chk("b2b_busy21", c, 8'(b1.busy), 8'h0);
        chk("b2b_out21",  c, 8'(b1.out),  8'h1);
      end
      chk("b2b_ready", c, 8'(b1.ready), (c >= 4 && c <= 11) ? 8'h0 : 8'h1);
      chk("b2b_done",  c, 8'(b1.done),  (c == 11 || c == 21) ? 8'h1 : 8'h0);
      b1.start = 1'b0; b1.data_in = 8'h00;
      if (c == 3) begin b1.start = 1'b1; b1.data_in = 8'hFF; end
      if (c == 6) begin b1.start = 1'b1; b1.data_in = 8'h3C; end
      step();
    end
    b1.start = 1'b0;
    for (int c = 22; c <= 25; c++) begin
      chk("ign_out",  c, 8'(b1.out),  8'h1);
      chk("ign_busy", c, 8'(b1.busy), 8'h0);
      step();
    end

    // CLKS_PER_BIT=4, two stop bits, 0x81
    b2.start = 1'b1; b2.data_in = 8'h81;
    step();
    b2.start = 1'b0; b2.data_in = 8'hFF;
    for (int c = 1; c <= 44; c++) begin
      chk("cpb4_out",  c, 8'(b2.out),  8'(f_81[(c-1)/4]));
      chk("cpb4_busy", c, 8'(b2.busy), 8'h1);
      chk("cpb4_done", c, 8'(b2.done), 8'h0);
      step();
    end
    chk("cpb4_done45", 45, 8'(b2.done), 8'h1);
    chk("cpb4_busy45", 45, 8'(b2.busy), 8'h0);
    step();
    chk("cpb4_done46", 46, 8'(b2.done), 8'h0);
    step();

    // reset during data bit 3 of 0xF0 with 0x11 buffered
    b1.start = 1'b1; b1.data_in = 8'hF0;
    step();
    b1.start = 1'b0;
    step();
    b1.start = 1'b1; b1.data_in = 8'h11;
    step();
    b1.start = 1'b0;
    chk("mid_ready3", 3, 8'(b1.ready), 8'h0);
    step();
    step();
    chk("mid_bit3", 5, 8'(b1.out), 8'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out",   5, 8'(b1.out),   8'h1);
    chk("mid_rst_busy",  5, 8'(b1.busy),  8'h0);
    chk("mid_rst_ready", 5, 8'(b1.ready), 8'h1);
    chk("mid_rst_done",  5, 8'(b1.done),  8'h0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_out",  c, 8'(b1.out),  8'h1);
      chk("post_rst_busy", c, 8'(b1.busy), 8'h0);
    end
    b1.start = 1'b1; b1.data_in = 8'h55;
    step();
    b1.start = 1'b0; b1.data_in = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      chk("p55_out",  c, 8'(b1.out),  8'(f_55[c-1]));
      chk("p55_busy", c, 8'(b1.busy), 8'h1);
      step();
    end
    chk("p55_done", 11, 8'(b1.done), 8'h1);
    step();
    chk("p55_idle", 12, 8'(b1.busy), 8'h0);
    chk("p55_out12", 12, 8'(b1.out), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
